// File: rtl/cordic_request_arbiter.sv
// Round-robin arbiter sharing one fixed-latency CORDIC core between two requesters.
// Optional per-channel accept counters are built when CHORD_ARB_STATS_EN is defined.
module cordic_request_arbiter #(
  parameter int DATA_WIDTH   = 16,
  parameter int PIPE_LATENCY = 8,
  parameter int CNT_WIDTH    = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req0_valid,
  output logic                         req0_ready,
  input  logic signed [DATA_WIDTH-1:0] req0_x,
  input  logic signed [DATA_WIDTH-1:0] req0_y,
  input  logic signed [DATA_WIDTH-1:0] req0_degree,
  input  logic                         req0_arctan_en,
  input  logic                         req1_valid,
  output logic                         req1_ready,
  input  logic signed [DATA_WIDTH-1:0] req1_x,
  input  logic signed [DATA_WIDTH-1:0] req1_y,
  input  logic signed [DATA_WIDTH-1:0] req1_degree,
  input  logic                         req1_arctan_en,
  output logic                         core_valid_in,
  output logic signed [DATA_WIDTH-1:0] core_x,
  output logic signed [DATA_WIDTH-1:0] core_y,
  output logic signed [DATA_WIDTH-1:0] core_degree,
  output logic                         core_arctan_en,
  input  logic                         core_valid_out,
  input  logic [31:0]                  core_data_out,
  output logic                         rsp0_valid,
  output logic [31:0]                  rsp0_data,
  output logic                         rsp1_valid,
  output logic [31:0]                  rsp1_data,
  input  logic                         flush_req,
  output logic                         flush_done,
  output logic                         busy,
  output logic                         tag_err
`ifdef CHORD_ARB_STATS_EN
  ,
  output logic [15:0]                  stat_issue0,
  output logic [15:0]                  stat_issue1
`endif
);

  localparam int TAIL = PIPE_LATENCY - 1;

  typedef enum logic [1:0] {IDLE, DRAIN, DONE} state_t;

  state_t                  state, state_nxt;
  logic                    rr_ptr;
  logic                    grant0, grant1, xfer, contested;
  logic [CNT_WIDTH-1:0]    inflight;
  logic                    own_p0;
  logic [PIPE_LATENCY-1:0] tag_vld, tag_own;
  logic                    tail_vld, tail_own, hit;

  always_comb begin
    state_nxt = state;
    grant0    = 1'b0;
    grant1    = 1'b0;
    case (state)
      IDLE: begin
        // A rising flush takes priority over any grant in the same cycle.
        if (flush_req) begin
          state_nxt = DRAIN;
        end else if (req0_valid && req1_valid) begin
          grant0 = ~rr_ptr;
          grant1 = rr_ptr;
        end else begin
          grant0 = req0_valid;
          grant1 = req1_valid;
        end
      end
      DRAIN:   if (inflight == '0) state_nxt = DONE;
      DONE:    if (!flush_req) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign req0_ready = grant0 & ~rst;
  assign req1_ready = grant1 & ~rst;
  assign xfer       = req0_ready | req1_ready;
  assign contested  = xfer & req0_valid & req1_valid;
  assign flush_done = (state == DONE) & flush_req;
  assign busy       = (inflight != '0);
  assign tail_vld   = tag_vld[TAIL];
  assign tail_own   = tag_own[TAIL];
  assign hit        = core_valid_out & tail_vld;

  // Control: FSM, round-robin pointer, in-flight count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      rr_ptr   <= 1'b0;
      inflight <= '0;
    end else begin
      state <= state_nxt;
      if (contested) rr_ptr <= ~rr_ptr;
      case ({xfer, tail_vld})
        2'b10:   inflight <= inflight + CNT_WIDTH'(1);
        2'b01:   inflight <= inflight - CNT_WIDTH'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  // Stage p0: operands registered toward the core.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      core_valid_in  <= 1'b0;
      core_x         <= '0;
      core_y         <= '0;
      core_degree    <= '0;
      core_arctan_en <= 1'b0;
      own_p0         <= 1'b0;
    end else begin
      core_valid_in <= xfer;
      if (xfer) begin
        core_x         <= req1_ready ? req1_x         : req0_x;
        core_y         <= req1_ready ? req1_y         : req0_y;
        core_degree    <= req1_ready ? req1_degree    : req0_degree;
        core_arctan_en <= req1_ready ? req1_arctan_en : req0_arctan_en;
        own_p0         <= req1_ready;
      end
    end
  end

  // Tag pipe: tail stage lines up with core_valid_out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_vld <= '0;
      tag_own <= '0;
    end else begin
      for (int i = PIPE_LATENCY - 1; i > 0; i--) begin
        tag_vld[i] <= tag_vld[i-1];
        tag_own[i] <= tag_own[i-1];
      end
      tag_vld[0] <= core_valid_in;
      tag_own[0] <= own_p0;
    end
  end

  // Response stage: route the core result to its owner.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp0_valid <= 1'b0;
      rsp0_data  <= '0;
      rsp1_valid <= 1'b0;
      rsp1_data  <= '0;
      tag_err    <= 1'b0;
    end else begin
      rsp0_valid <= hit & ~tail_own;
      rsp1_valid <= hit & tail_own;
      if (hit && !tail_own) rsp0_data <= core_data_out;
      if (hit && tail_own)  rsp1_data <= core_data_out;
      if (core_valid_out != tail_vld) tag_err <= 1'b1;
    end
  end

`ifdef CHORD_ARB_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_issue0 <= '0;
      stat_issue1 <= '0;
    end else if (state == DONE) begin
      stat_issue0 <= '0;
      stat_issue1 <= '0;
    end else begin
      if (req0_ready) stat_issue0 <= sat_inc(stat_issue0);
      if (req1_ready) stat_issue1 <= sat_inc(stat_issue1);
    end
  end
`endif

endmodule
